// File: rtl/temac_tx_client_fifo.sv
// Store-and-forward transmit FIFO for the tri-mode MAC client TX interface.
// User bytes are queued as {eof,data}; a frame is offered to the MAC only
// once its eof byte is stored, and stays reserved until it finishes, so a
// collision with retransmit can replay it from its first byte.
module temac_tx_client_fifo #(
  parameter int unsigned ADDR_W     = 11,
  parameter int unsigned MAX_FRAMES = 15,
  localparam int unsigned CW        = $clog2(MAX_FRAMES + 1)
) (
  input  logic          txcoreclk,
  input  logic          reset,
  input  logic [7:0]    wr_data,
  input  logic          wr_valid,
  input  logic          wr_eof,
  output logic          wr_ready,
  output logic          wr_overflow,
  output logic [7:0]    clientemactxd,
  output logic          clientemactxdvld,
  input  logic          emacclienttxack,
  input  logic          emacclienttxcollision,
  input  logic          emacclienttxretransmit,
  output logic          clientemactxunderrun,
  output logic [CW-1:0] frame_count
);

  localparam int unsigned     DEPTH  = 2 ** ADDR_W;
  localparam logic [CW-1:0]   MAX_FC = CW'(MAX_FRAMES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_ACK, S_SEND, S_FLUSH} state_t;

  logic [8:0]      mem_q [DEPTH];
  logic [8:0]      rd_word;

  state_t          state_q, state_d;
  logic [ADDR_W:0] wr_ptr_q, wr_ptr_d, wr_start_q, wr_start_d;
  logic [ADDR_W:0] rd_ptr_q, rd_ptr_d, rd_start_q, rd_start_d;
  logic [CW-1:0]   fc_q, fc_d;
  logic            discard_q, discard_d;
  logic            live_q;
  logic [7:0]      txd_q, txd_d;
  logic            dvld_q, dvld_d;
  logic            eof_cur_q, eof_cur_d;

  logic [ADDR_W:0] used, full_lvl;
  logic            full, overflow_now, discarding, wr_en, commit, release_frm;

  // One slot is kept free, so the largest frame that fits is DEPTH-1 bytes.
  assign full_lvl     = {1'b0, {ADDR_W{1'b1}}};
  assign used         = wr_ptr_q - rd_start_q;
  assign full         = (used >= full_lvl);
  assign overflow_now = live_q & full & (fc_q == '0) & ~discard_q;
  assign discarding   = discard_q | overflow_now;
  assign wr_ready     = live_q & (discarding | (~full & (fc_q < MAX_FC)));
  assign wr_en        = wr_valid & wr_ready & ~discarding;
  assign commit       = wr_en & wr_eof;
  assign rd_word      = mem_q[rd_ptr_q[ADDR_W-1:0]];

  assign wr_overflow          = overflow_now;
  assign clientemactxd        = txd_q;
  assign clientemactxdvld     = dvld_q;
  assign clientemactxunderrun = 1'b0;
  assign frame_count          = fc_q;

  // Frame storage write port.
  always_ff @(posedge txcoreclk) begin
    if (wr_en) mem_q[wr_ptr_q[ADDR_W-1:0]] <= {wr_eof, wr_data};
  end

  // Write pointer, commit point and overflow discard tracking.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    wr_start_d = wr_start_q;
    discard_d  = discard_q;
    if (overflow_now) begin
      // The byte offered in the overflow cycle is already part of the discard.
      wr_ptr_d  = wr_start_q;
      discard_d = ~(wr_valid & wr_eof);
    end else if (discard_q) begin
      if (wr_valid & wr_eof) discard_d = 1'b0;
    end else if (wr_en) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      if (wr_eof) wr_start_d = wr_ptr_q + 1'b1;
    end
  end

  // State register and all registered outputs.
  always_ff @(posedge txcoreclk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      wr_start_q <= '0;
      rd_ptr_q   <= '0;
      rd_start_q <= '0;
      fc_q       <= '0;
      discard_q  <= 1'b0;
      live_q     <= 1'b0;
      txd_q      <= '0;
      dvld_q     <= 1'b0;
      eof_cur_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      wr_start_q <= wr_start_d;
      rd_ptr_q   <= rd_ptr_d;
      rd_start_q <= rd_start_d;
      fc_q       <= fc_d;
      discard_q  <= discard_d;
      live_q     <= 1'b1;
      txd_q      <= txd_d;
      dvld_q     <= dvld_d;
      eof_cur_q  <= eof_cur_d;
    end
  end

  // Read FSM next-state; collision takes priority over ack and end of frame.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (fc_q != '0) state_d = S_WAIT_ACK;
      S_WAIT_ACK: begin
        if (emacclienttxcollision)
          state_d = emacclienttxretransmit ? S_IDLE : S_FLUSH;
        else if (emacclienttxack)
          state_d = eof_cur_q ? S_IDLE : S_SEND;
      end
      S_SEND: begin
        if (emacclienttxcollision)
          state_d = emacclienttxretransmit ? S_IDLE : S_FLUSH;
        else if (eof_cur_q)
          state_d = S_IDLE;
      end
      S_FLUSH:    if (eof_cur_q) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Read datapath: eof_cur_q flags the entry most recently fetched, and
  // rd_ptr_q always points one past it.
  always_comb begin
    txd_d       = txd_q;
    dvld_d      = dvld_q;
    eof_cur_d   = eof_cur_q;
    rd_ptr_d    = rd_ptr_q;
    rd_start_d  = rd_start_q;
    release_frm = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (fc_q != '0) begin
          txd_d     = rd_word[7:0];
          eof_cur_d = rd_word[8];
          dvld_d    = 1'b1;
          rd_ptr_d  = rd_ptr_q + 1'b1;
        end
      end
      S_WAIT_ACK, S_SEND: begin
        if (emacclienttxcollision) begin
          dvld_d = 1'b0;
          if (emacclienttxretransmit) rd_ptr_d = rd_start_q;
        end else if ((state_q == S_WAIT_ACK) && !emacclienttxack) begin
          dvld_d = 1'b1;
        end else if (eof_cur_q) begin
          dvld_d      = 1'b0;
          release_frm = 1'b1;
        end else begin
          txd_d     = rd_word[7:0];
          eof_cur_d = rd_word[8];
          dvld_d    = 1'b1;
          rd_ptr_d  = rd_ptr_q + 1'b1;
        end
      end
      S_FLUSH: begin
        if (eof_cur_q) begin
          release_frm = 1'b1;
        end else begin
          eof_cur_d = rd_word[8];
          rd_ptr_d  = rd_ptr_q + 1'b1;
        end
      end
      default: dvld_d = 1'b0;
    endcase
    if (release_frm) rd_start_d = rd_ptr_q;
  end

  // Stored-frame count; commit and release in one cycle cancel out.
  always_comb begin
    fc_d = fc_q;
    case ({commit, release_frm})
      2'b10:   fc_d = fc_q + 1'b1;
      2'b01:   fc_d = fc_q - 1'b1;
      default: fc_d = fc_q;
    endcase
  end

endmodule

// File: tb/tb_temac_tx_client_fifo.sv
// Self-checking bench for temac_tx_client_fifo: a default-size instance and
// an ADDR_W=6 instance share clock/reset; sel steers the user and MAC-side
// stimulus to one of them. Expected frames are the bytes the bench wrote.
module tb_temac_tx_client_fifo;

  typedef logic [7:0] bq_t[$];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       sel = 1'b0;
  logic [7:0] wr_data = '0;
  logic       wr_valid = 1'b0, wr_eof = 1'b0;
  logic       ack = 1'b0, col = 1'b0, retx = 1'b0;

  logic       m_wr_valid, m_ack, m_col, m_wr_ready, m_ovf, m_dvld, m_unr;
  logic [7:0] m_txd;
  logic [3:0] m_fc;
  logic       s_wr_valid, s_ack, s_col, s_wr_ready, s_ovf, s_dvld, s_unr;
  logic [7:0] s_txd;
  logic [3:0] s_fc;

  logic       cur_wr_ready, cur_ovf, cur_dvld;
  logic [7:0] cur_txd;
  logic [3:0] cur_fc;

  assign m_wr_valid = wr_valid & ~sel;
  assign s_wr_valid = wr_valid & sel;
  assign m_ack = ack & ~sel;
  assign s_ack = ack & sel;
  assign m_col = col & ~sel;
  assign s_col = col & sel;
  assign cur_wr_ready = sel ? s_wr_ready : m_wr_ready;
  assign cur_ovf      = sel ? s_ovf      : m_ovf;
  assign cur_dvld     = sel ? s_dvld     : m_dvld;
  assign cur_txd      = sel ? s_txd      : m_txd;
  assign cur_fc       = sel ? s_fc       : m_fc;

  temac_tx_client_fifo #(.ADDR_W(11), .MAX_FRAMES(15)) u_dut (
    .txcoreclk(clk), .reset(rst),
    .wr_data(wr_data), .wr_valid(m_wr_valid), .wr_eof(wr_eof),
    .wr_ready(m_wr_ready), .wr_overflow(m_ovf),
    .clientemactxd(m_txd), .clientemactxdvld(m_dvld),
    .emacclienttxack(m_ack), .emacclienttxcollision(m_col),
    .emacclienttxretransmit(retx), .clientemactxunderrun(m_unr),
    .frame_count(m_fc)
  );

  temac_tx_client_fifo #(.ADDR_W(6), .MAX_FRAMES(15)) u_small (
    .txcoreclk(clk), .reset(rst),
    .wr_data(wr_data), .wr_valid(s_wr_valid), .wr_eof(wr_eof),
    .wr_ready(s_wr_ready), .wr_overflow(s_ovf),
    .clientemactxd(s_txd), .clientemactxdvld(s_dvld),
    .emacclienttxack(s_ack), .emacclienttxcollision(s_col),
    .emacclienttxretransmit(retx), .clientemactxunderrun(s_unr),
    .frame_count(s_fc)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Peak frame_count while mon_en is set; small-instance dvld activity.
  logic mon_en = 1'b0;
  int   fc_max = 0;
  int   s_dvld_cnt = 0;
  always @(negedge clk) begin
    if (!mon_en) fc_max = 0;
    else if (int'(m_fc) > fc_max) fc_max = int'(m_fc);
    if (s_dvld === 1'b1) s_dvld_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running, required to finish");
    $fatal(1);
  end

  function automatic bq_t make_frame(input int len, input bit ramp);
    bq_t f;
    for (int i = 0; i < len; i++) f.push_back(ramp ? 8'(i) : 8'($urandom));
    return f;
  endfunction

  // Index of the first differing byte (or shorter length), -1 if identical.
  function automatic int first_diff(input bq_t a, input bq_t b);
    int n;
    n = (a.size() < b.size()) ? a.size() : b.size();
    for (int i = 0; i < n; i++) if (a[i] !== b[i]) return i;
    if (a.size() != b.size()) return n;
    return -1;
  endfunction

  task automatic write_frame(input bq_t f, output int ovf_cnt, output int ovf_idx);
    int i = 0;
    int guard = 0;
    ovf_cnt = 0;
    ovf_idx = -1;
    while (i < f.size() && guard < 4000) begin
      @(negedge clk);
      guard++;
      wr_valid = 1'b1;
      wr_data  = f[i];
      wr_eof   = (i == f.size() - 1);
      if (cur_ovf === 1'b1) begin
        ovf_cnt++;
        if (ovf_idx < 0) ovf_idx = i;
      end
      if (cur_wr_ready === 1'b1) i++;
    end
    if (i < f.size()) begin
      n_tests++; n_fail++;
      $display("FAIL write_timeout: accepted %0d bytes, required %0d", i, f.size());
    end
    @(negedge clk);
    wr_valid = 1'b0;
    wr_eof   = 1'b0;
  endtask

  // MAC model: hold first byte ack_dly cycles, then collect the stream.
  // col_at >= 1 raises a collision while that byte index is presented.
  task automatic mac_recv(input bq_t exp, input int ack_dly, input int col_at,
                          input bit rtx, output bq_t got, output int fc0);
    int   guard = 0;
    bit   hold_bad = 0;
    logic [7:0] bad_txd = '0;
    got = {};
    fc0 = -1;
    while (cur_dvld !== 1'b1 && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    n_tests++;
    if (cur_dvld !== 1'b1) begin
      n_fail++;
      $display("FAIL recv_start: dvld=%b after %0d cycles, required 1", cur_dvld, guard);
      return;
    end
    fc0 = int'(cur_fc);
    got.push_back(cur_txd);
    for (int h = 1; h <= ack_dly; h++) begin
      if (h > 1) @(negedge clk);
      if (cur_dvld !== 1'b1 || cur_txd !== exp[0]) begin
        hold_bad = 1;
        bad_txd  = cur_txd;
      end
      if (h == ack_dly) ack = 1'b1;
    end
    @(negedge clk);
    ack = 1'b0;
    n_tests++;
    if (hold_bad) begin
      n_fail++;
      $display("FAIL first_byte_hold: txd=%02h during ack wait, required %02h with dvld=1", bad_txd, exp[0]);
    end
    guard = 0;
    while (cur_dvld === 1'b1 && guard < 5000) begin
      got.push_back(cur_txd);
      if (got.size() - 1 == col_at) begin
        col  = 1'b1;
        retx = rtx;
        @(negedge clk);
        col  = 1'b0;
        retx = 1'b0;
        return;
      end
      @(negedge clk);
      guard++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++; if (m_wr_ready !== 1'b0) begin n_fail++; $display("FAIL rst_wr_ready: got %b, required 0", m_wr_ready); end
    n_tests++; if (m_dvld !== 1'b0) begin n_fail++; $display("FAIL rst_dvld: got %b, required 0", m_dvld); end
    n_tests++; if (m_txd !== 8'h00) begin n_fail++; $display("FAIL rst_txd: got %02h, required 00", m_txd); end
    n_tests++; if (m_fc !== 4'd0) begin n_fail++; $display("FAIL rst_fc: got %0d, required 0", m_fc); end
    n_tests++; if (m_ovf !== 1'b0 || m_unr !== 1'b0) begin n_fail++; $display("FAIL rst_ovf_unr: got %b/%b, required 0/0", m_ovf, m_unr); end
    n_tests++; if (s_wr_ready !== 1'b0) begin n_fail++; $display("FAIL rst_small_ready: got %b, required 0", s_wr_ready); end
    rst = 1'b0;
    @(negedge clk);
    n_tests++; if (m_wr_ready !== 1'b1 || s_wr_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready: got %b/%b, required 1/1", m_wr_ready, s_wr_ready); end
  endtask

  task automatic test_ramp_frame();
    bq_t f, got;
    int oc, oi, fc0, d;
    f = make_frame(60, 1'b1);
    write_frame(f, oc, oi);
    n_tests++; if (oc != 0) begin n_fail++; $display("FAIL t1_ovf: got %0d pulses, required 0", oc); end
    n_tests++; if (m_dvld !== 1'b0 || m_fc !== 4'd1) begin n_fail++; $display("FAIL t1_eof_plus1: dvld=%b fc=%0d, required 0 and 1", m_dvld, m_fc); end
    @(negedge clk);
    n_tests++; if (m_dvld !== 1'b1 || m_txd !== 8'h00) begin n_fail++; $display("FAIL t1_eof_plus2: dvld=%b txd=%02h, required 1 and 00", m_dvld, m_txd); end
    mac_recv(f, 5, -1, 1'b0, got, fc0);
    d = first_diff(got, f);
    n_tests++; if (d >= 0) begin n_fail++; $display("FAIL t1_data: %0d bytes, first diff at %0d, required 60 bytes 00..3B", got.size(), d); end
    n_tests++; if (fc0 != 1 || m_fc !== 4'd0) begin n_fail++; $display("FAIL t1_fc: start %0d end %0d, required 1 then 0", fc0, m_fc); end
  endtask

  task automatic test_back_to_back();
    bq_t a, b, ga, gb;
    int oca, oia, ocb, oib, fca, fcb, da, db;
    a = make_frame(64, 1'b0);
    b = make_frame(64, 1'b0);
    mon_en = 1'b1;
    write_frame(a, oca, oia);
    fork
      write_frame(b, ocb, oib);
      mac_recv(a, int'($urandom_range(1, 4)), -1, 1'b0, ga, fca);
    join
    n_tests++; if (m_dvld !== 1'b0) begin n_fail++; $display("FAIL t2_gap: dvld=%b after frame A, required 0", m_dvld); end
    mac_recv(b, int'($urandom_range(1, 4)), -1, 1'b0, gb, fcb);
    da = first_diff(ga, a);
    db = first_diff(gb, b);
    n_tests++; if (da >= 0) begin n_fail++; $display("FAIL t2_frame_a: %0d bytes, first diff at %0d, required 64 intact", ga.size(), da); end
    n_tests++; if (db >= 0) begin n_fail++; $display("FAIL t2_frame_b: %0d bytes, first diff at %0d, required 64 intact", gb.size(), db); end
    n_tests++; if (fc_max > 2 || m_fc !== 4'd0) begin n_fail++; $display("FAIL t2_fc: peak %0d end %0d, required <=2 and 0", fc_max, m_fc); end
    mon_en = 1'b0;
  endtask

  task automatic test_collision_retx();
    bq_t f, got;
    int oc, oi, fc0, d;
    f = make_frame(64, 1'b0);
    write_frame(f, oc, oi);
    mac_recv(f, int'($urandom_range(1, 4)), 20, 1'b1, got, fc0);
    n_tests++; if (m_dvld !== 1'b0 || m_fc !== 4'd1) begin n_fail++; $display("FAIL t3_after_col: dvld=%b fc=%0d, required 0 and 1", m_dvld, m_fc); end
    mac_recv(f, int'($urandom_range(1, 4)), -1, 1'b0, got, fc0);
    d = first_diff(got, f);
    n_tests++; if (d >= 0) begin n_fail++; $display("FAIL t3_replay: %0d bytes, first diff at %0d, required all 64", got.size(), d); end
    n_tests++; if (fc0 != 1 || m_fc !== 4'd0) begin n_fail++; $display("FAIL t3_fc: start %0d end %0d, required 1 then 0", fc0, m_fc); end
  endtask

  task automatic test_collision_drop();
    bq_t x, y, got;
    int oc, oi, fc0, d;
    x = make_frame(64, 1'b0);
    y = make_frame(int'($urandom_range(2, 50)), 1'b0);
    write_frame(x, oc, oi);
    write_frame(y, oc, oi);
    n_tests++; if (m_fc !== 4'd2) begin n_fail++; $display("FAIL t4_queued: fc=%0d, required 2", m_fc); end
    mac_recv(x, int'($urandom_range(1, 4)), 10, 1'b0, got, fc0);
    n_tests++; if (m_dvld !== 1'b0) begin n_fail++; $display("FAIL t4_after_col: dvld=%b, required 0", m_dvld); end
    mac_recv(y, int'($urandom_range(1, 4)), -1, 1'b0, got, fc0);
    d = first_diff(got, y);
    n_tests++; if (d >= 0) begin n_fail++; $display("FAIL t4_next_frame: %0d bytes, first diff at %0d, required %0d intact", got.size(), d, y.size()); end
    n_tests++; if (fc0 != 1 || m_fc !== 4'd0) begin n_fail++; $display("FAIL t4_fc: start %0d end %0d, required 1 then 0", fc0, m_fc); end
  endtask

  // ADDR_W=6: 63 bytes fill the FIFO, so the pulse comes with the 64th byte.
  task automatic test_overflow();
    bq_t f, g, got;
    int oc, oi, fc0, d;
    sel = 1'b1;
    f = make_frame(80, 1'b0);
    write_frame(f, oc, oi);
    repeat (5) @(negedge clk);
    n_tests++; if (oc != 1 || oi != 63) begin n_fail++; $display("FAIL t5_ovf_pulse: %0d pulses at byte %0d, required 1 at byte 63", oc, oi); end
    n_tests++; if (s_dvld_cnt != 0 || s_fc !== 4'd0) begin n_fail++; $display("FAIL t5_dropped: dvld cycles %0d fc %0d, required 0 and 0", s_dvld_cnt, s_fc); end
    g = make_frame(20, 1'b0);
    write_frame(g, oc, oi);
    mac_recv(g, int'($urandom_range(1, 4)), -1, 1'b0, got, fc0);
    d = first_diff(got, g);
    n_tests++; if (d >= 0 || oc != 0) begin n_fail++; $display("FAIL t5_next_frame: %0d bytes diff at %0d ovf %0d, required 20 intact, 0", got.size(), d, oc); end
    n_tests++; if (s_fc !== 4'd0) begin n_fail++; $display("FAIL t5_fc_end: got %0d, required 0", s_fc); end
    sel = 1'b0;
  endtask

  task automatic test_reset_mid_send();
    bq_t f, got;
    int oc, oi, fc0, d, guard;
    f = make_frame(64, 1'b0);
    write_frame(f, oc, oi);
    guard = 0;
    while (m_dvld !== 1'b1 && guard < 100) begin @(negedge clk); guard++; end
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    repeat (5) @(negedge clk);
    n_tests++; if (m_dvld !== 1'b1) begin n_fail++; $display("FAIL t6_sending: dvld=%b, required 1", m_dvld); end
    rst = 1'b1;
    @(negedge clk);
    n_tests++; if (m_dvld !== 1'b0 || m_fc !== 4'd0 || m_wr_ready !== 1'b0) begin n_fail++; $display("FAIL t6_reset: dvld=%b fc=%0d ready=%b, required 0/0/0", m_dvld, m_fc, m_wr_ready); end
    rst = 1'b0;
    @(negedge clk);
    f = make_frame(1, 1'b0);
    write_frame(f, oc, oi);
    mac_recv(f, int'($urandom_range(1, 4)), -1, 1'b0, got, fc0);
    d = first_diff(got, f);
    n_tests++; if (d >= 0) begin n_fail++; $display("FAIL t6_one_byte: %0d bytes, first diff at %0d, required 1 byte ending on ack", got.size(), d); end
    n_tests++; if (m_dvld !== 1'b0 || m_fc !== 4'd0) begin n_fail++; $display("FAIL t6_end: dvld=%b fc=%0d, required 0 and 0", m_dvld, m_fc); end
  endtask

  // Several random frames queued at once, then drained in order.
  task automatic test_random_frames();
    logic [7:0] exp_bytes[$];
    int exp_len[$];
    bq_t f, got;
    int oc, oi, fc0, d, nfr;
    nfr = int'($urandom_range(3, 6));
    for (int k = 0; k < nfr; k++) begin
      f = make_frame(int'($urandom_range(1, 100)), 1'b0);
      exp_len.push_back(f.size());
      foreach (f[i]) exp_bytes.push_back(f[i]);
      write_frame(f, oc, oi);
    end
    n_tests++; if (int'(m_fc) != nfr) begin n_fail++; $display("FAIL rnd_queued: fc=%0d, required %0d", m_fc, nfr); end
    for (int k = 0; k < nfr; k++) begin
      f = {};
      for (int i = 0; i < exp_len[k]; i++) f.push_back(exp_bytes.pop_front());
      mac_recv(f, int'($urandom_range(1, 6)), -1, 1'b0, got, fc0);
      d = first_diff(got, f);
      n_tests++; if (d >= 0 || fc0 != nfr - k) begin n_fail++; $display("FAIL rnd_frame%0d: %0d bytes diff at %0d fc %0d, required %0d intact fc %0d", k, got.size(), d, fc0, f.size(), nfr - k); end
    end
  endtask

  initial begin
    test_reset();
    test_ramp_frame();
    test_back_to_back();
    test_collision_retx();
    test_collision_drop();
    test_overflow();
    test_reset_mid_send();
    test_random_frames();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
